// File: rtl/proc_control_unit_pkg.sv
// Shared definitions for the processor control sequencer: step and opcode
// encodings, ALU op codes and default field widths.
package proc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 4;
  localparam int DEF_REG_W  = 3;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // True for the three opcodes that walk through T2/T3.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // ALU function select; anything unexpected falls back to add.
  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    logic [1:0] sel;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Control bus between the sequencer (slave side) and the datapath / stimulus
// source (master side): run request, instruction word and all enables.
interface proc_control_unit_if
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
);
  localparam int NREG = 2 ** REG_W;

  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic              IRin;
  logic [NREG-1:0]   Rout;
  logic [NREG-1:0]   Rin;
  logic              DINout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic [1:0]        AluOp;
  logic              Done;
  logic [1:0]        Step;
  logic [15:0]       InstrCount;

  modport master (
    output Run, DIN,
    input  IRin, Rout, Rin, DINout, Ain, Gin, Gout, AluOp, Done, Step, InstrCount
  );

  modport slave (
    input  Run, DIN,
    output IRin, Rout, Rin, DINout, Ain, Gin, Gout, AluOp, Done, Step, InstrCount
  );
endinterface

// File: rtl/proc_control_unit_onehot_decoder.sv
// Register-field decoder: binary select to one-hot, all zeros when disabled.
module onehot_decoder #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [2**REG_W-1:0]   o_onehot
);

  // Set exactly one bit for the selected register when enabled.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end else begin
      o_onehot = '0;
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Control sequencer for the bus-based processor: fetches IR from DIN in T0,
// steps T1..T3 and decodes every datapath enable from (step, IR, Run).
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  proc_control_unit_if.slave   bus
);
  localparam int IR_W = OP_W + 2 * REG_W;
  localparam int NREG = 2 ** REG_W;

  step_e             r_step;
  step_e             w_step_nxt;
  logic [IR_W-1:0]   r_ir;
  logic [15:0]       r_instr_count;

  logic [OP_W-1:0]   w_op;
  logic [REG_W-1:0]  w_x;
  logic [REG_W-1:0]  w_y;
  logic              w_is_alu;
  logic [NREG-1:0]   w_x_oh;
  logic [NREG-1:0]   w_y_oh;

  logic              w_irin;
  logic [NREG-1:0]   w_rout;
  logic [NREG-1:0]   w_rin;
  logic              w_dinout;
  logic              w_ain;
  logic              w_gin;
  logic              w_gout;
  logic [1:0]        w_aluop;
  logic              w_done;

  assign w_op     = r_ir[IR_W-1 -: OP_W];
  assign w_x      = r_ir[2*REG_W-1 -: REG_W];
  assign w_y      = r_ir[REG_W-1:0];
  assign w_is_alu = is_alu_op(w_op);

  onehot_decoder #(.REG_W(REG_W)) u_dec_x (
    .i_sel    (w_x),
    .i_en     (~Reset),
    .o_onehot (w_x_oh)
  );

  onehot_decoder #(.REG_W(REG_W)) u_dec_y (
    .i_sel    (w_y),
    .i_en     (~Reset),
    .o_onehot (w_y_oh)
  );

  // Step register; reset drops straight back to fetch, discarding any partial instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_step <= T0;
    end else begin
      r_step <= w_step_nxt;
    end
  end

  // Next step: only ALU ops reach T2/T3; every other path returns to fetch.
  always_comb begin
    w_step_nxt = T0;
    case (r_step)
      T0:      w_step_nxt = bus.Run ? T1 : T0;
      T1:      w_step_nxt = w_is_alu ? T2 : T0;
      T2:      w_step_nxt = w_is_alu ? T3 : T0;
      T3:      w_step_nxt = T0;
      default: w_step_nxt = T0;
    endcase
  end

  // Enable decode; everything is held low while Reset is asserted.
  always_comb begin
    w_irin   = 1'b0;
    w_rout   = '0;
    w_rin    = '0;
    w_dinout = 1'b0;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_gout   = 1'b0;
    w_aluop  = ALU_ADD;
    w_done   = 1'b0;
    if (Reset) begin
      w_irin = 1'b0;
    end else begin
      case (r_step)
        T0: w_irin = bus.Run;
        T1: begin
          case (w_op)
            OP_MV: begin
              w_rout = w_y_oh;
              w_rin  = w_x_oh;
              w_done = 1'b1;
            end
            OP_MVI: begin
              w_dinout = 1'b1;
              w_rin    = w_x_oh;
              w_done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              w_rout = w_x_oh;
              w_ain  = 1'b1;
            end
            default: w_done = 1'b1;
          endcase
        end
        T2: begin
          if (w_is_alu) begin
            w_rout  = w_y_oh;
            w_gin   = 1'b1;
            w_aluop = alu_sel(w_op);
          end else begin
            w_done = 1'b1;
          end
        end
        T3: begin
          if (w_is_alu) begin
            w_gout = 1'b1;
            w_rin  = w_x_oh;
            w_done = 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end
        default: w_done = 1'b0;
      endcase
    end
  end

  // Instruction register, loaded from the top bits of DIN on a fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ir <= '0;
    end else if (w_irin) begin
      r_ir <= bus.DIN[DATA_W-1 -: IR_W];
    end else begin
      r_ir <= r_ir;
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_instr_count <= 16'h0000;
    end else if (w_done) begin
      r_instr_count <= r_instr_count + 16'h0001;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign bus.IRin       = w_irin;
  assign bus.Rout       = w_rout;
  assign bus.Rin        = w_rin;
  assign bus.DINout     = w_dinout;
  assign bus.Ain        = w_ain;
  assign bus.Gin        = w_gin;
  assign bus.Gout       = w_gout;
  assign bus.AluOp      = w_aluop;
  assign bus.Done       = w_done;
  assign bus.Step       = r_step;
  assign bus.InstrCount = r_instr_count;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: each instruction is expanded into
// its expected per-cycle control pattern, queued, and checked by a monitor.
module tb_proc_control_unit;

  typedef struct packed {
    logic        irin;
    logic [7:0]  rout;
    logic [7:0]  rin;
    logic        dinout;
    logic        ain;
    logic        gin;
    logic        gout;
    logic [1:0]  aluop;
    logic        done;
    logic [1:0]  step;
    logic [15:0] cnt;
  } rec_t;

  logic clk;
  logic rst;

  proc_control_unit_if #(.DATA_W(16), .REG_W(3)) bus ();

  proc_control_unit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_cnt;
  rec_t        mon_e;
  rec_t        mon_a;
  int          n_drv;

  function automatic rec_t zrec(input logic [1:0] step);
    rec_t r;
    r      = '0;
    r.step = step;
    r.cnt  = m_cnt;
    return r;
  endfunction

  // One clock cycle: apply inputs, queue what the DUT must show this cycle.
  task automatic tick(input logic run, input logic [15:0] din, input logic r, input rec_t e);
    bus.Run = run;
    bus.DIN = din;
    rst     = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [15:0] rnd;
    for (int i = 0; i < n; i++) begin
      rnd = 16'($urandom);
      tick(1'b0, rnd, 1'b0, zrec(2'd0));
    end
  endtask

  // Expand one instruction into its micro-step table.
  task automatic do_instr(input logic [15:0] din, input logic [15:0] imm, input logic run_after);
    logic [3:0]  op;
    logic [7:0]  ohx;
    logic [7:0]  ohy;
    logic [15:0] rnd;
    rec_t        e;
    op  = din[15:12];
    ohx = 8'd1 << din[11:9];
    ohy = 8'd1 << din[8:6];
    rnd = 16'($urandom);
    e = zrec(2'd0);
    e.irin = 1'b1;
    tick(1'b1, din, 1'b0, e);
    e = zrec(2'd1);
    case (op)
      4'h0: begin
        e.rout = ohy; e.rin = ohx; e.done = 1'b1;
        tick(run_after, rnd, 1'b0, e);
        m_cnt = m_cnt + 16'd1;
      end
      4'h1: begin
        e.dinout = 1'b1; e.rin = ohx; e.done = 1'b1;
        tick(run_after, imm, 1'b0, e);
        m_cnt = m_cnt + 16'd1;
      end
      4'h2, 4'h4, 4'h5: begin
        e.rout = ohx; e.ain = 1'b1;
        tick(run_after, rnd, 1'b0, e);
        e = zrec(2'd2);
        e.rout = ohy; e.gin = 1'b1;
        e.aluop = (op == 4'h2) ? 2'b00 : ((op == 4'h4) ? 2'b01 : 2'b10);
        tick(run_after, rnd, 1'b0, e);
        e = zrec(2'd3);
        e.gout = 1'b1; e.rin = ohx; e.done = 1'b1;
        tick(run_after, rnd, 1'b0, e);
        m_cnt = m_cnt + 16'd1;
      end
      default: begin
        e.done = 1'b1;
        tick(run_after, rnd, 1'b0, e);
        m_cnt = m_cnt + 16'd1;
      end
    endcase
  endtask

  // Monitor: every mid-cycle sample is checked against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.IRin, bus.Rout, bus.Rin, bus.DINout, bus.Ain, bus.Gin, bus.Gout,
               bus.AluOp, bus.Done, bus.Step, bus.InstrCount};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got %h expected %h (irin,rout,rin,dinout,ain,gin,gout,aluop,done,step,cnt)",
                 $time, mon_a, mon_e);
      end
      n_cmp++;
      if (($countones(bus.Rout) + 32'(bus.DINout) + 32'(bus.Gout)) > 1 || $countones(bus.Rin) > 1) begin
        n_bad++;
        $display("FAIL bus_excl t=%0t got Rout=%h DINout=%b Gout=%b Rin=%h expected at most one driver and one Rin bit",
                 $time, bus.Rout, bus.DINout, bus.Gout, bus.Rin);
      end
    end
  end

  initial begin
    logic [15:0] din;
    logic [15:0] imm;
    logic [3:0]  op;
    rec_t        e;
    rst     = 1'b1;
    bus.Run = 1'b0;
    bus.DIN = 16'h0000;
    m_cnt   = 16'h0000;
    @(posedge clk);
    #1;
    // Reset state, with Run high to confirm IRin is held low.
    tick(1'b1, 16'h0040, 1'b1, zrec(2'd0));
    tick(1'b0, 16'h0000, 1'b1, zrec(2'd0));
    idle(5);

    // add aborted by Reset in T2: discarded, counter stays at 0.
    e = zrec(2'd0); e.irin = 1'b1;
    tick(1'b1, 16'h2480, 1'b0, e);
    e = zrec(2'd1); e.rout = 8'h04; e.ain = 1'b1;
    tick(1'b1, 16'h0000, 1'b0, e);
    m_cnt = 16'h0000;
    tick(1'b1, 16'h0000, 1'b1, zrec(2'd0));
    idle(2);

    // Directed instructions.
    do_instr(16'h0040, 16'h0000, 1'b0);   // mv R0,R1
    do_instr(16'h1200, 16'h00A5, 1'b0);   // mvi R1,#0xA5
    do_instr(16'h2480, 16'h0000, 1'b0);   // add R2,R2
    do_instr(16'h4480, 16'h0000, 1'b0);   // sub R2,R2, Run dropped after fetch
    do_instr(16'h5480, 16'h0000, 1'b1);   // and R2,R2, Run held high
    do_instr(16'h0240, 16'h0000, 1'b0);   // mv R1,R1
    idle(1);
    for (int i = 0; i < 4; i++) begin
      do_instr(16'hF000, 16'h0000, 1'b1); // NOPs back-to-back
    end

    // Counter wrap: preload 0xFFFF during an idle cycle, then retire NOPs.
    bus.Run = 1'b0;
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
    m_cnt = 16'hFFFF;
    exp_q.push_back(zrec(2'd0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      do_instr(16'hF3C0, 16'h0000, 1'b1);
    end

    // Randomised instruction stream.
    n_drv = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0:       op = 4'h0;
        1:       op = 4'h1;
        2:       op = 4'h2;
        3:       op = 4'h4;
        4:       op = 4'h5;
        default: op = 4'($urandom);
      endcase
      din = 16'($urandom);
      din[15:12] = op;
      imm = 16'($urandom);
      do_instr(din, imm, 1'($urandom));
      n_drv++;
      idle($urandom_range(0, 2));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
